// File: rtl/multicycle_controller.sv
// Multi-cycle opcode sequencer: FETCH/DECODE/EXEC plus optional MEM wait, BMAP burst and WB.
// Latency: 4 cycles minimum per instruction; MEM adds up to MEM_TIMEOUT cycles, BMAP adds BM_BEATS.
// Backpressure: Stall freezes state and counters and masks write/enable strobes; DMemReady completes MEM.
module multicycle_controller #(
    parameter int OP_W        = 4,
    parameter int BM_BEATS    = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      InstrValid,
    input  logic [OP_W-1:0]           OpCode,
    input  logic                      DMemReady,
    input  logic                      Stall,
    output logic                      InstrReq,
    output logic                      PCWrite,
    output logic                      RegWrite,
    output logic                      BitmapWrite,
    output logic [$clog2(BM_BEATS):0] BeatIdx,
    output logic                      DMemEn,
    output logic                      DMemWrite,
    output logic [1:0]                SignEx,
    output logic                      ALUAdd,
    output logic                      ALUSub,
    output logic                      CompAcc,
    output logic                      MemErr,
    output logic                      Busy,
    output logic                      Halted
);
    localparam int BW = $clog2(BM_BEATS) + 1;
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BM_BEATS - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BMAP, S_WB, S_HALT
    } state_t;

    state_t          state, nextState;
    logic [OP_W-1:0] opReg;
    logic [BW-1:0]   beatCnt;
    logic [TW-1:0]   toutCnt;
    logic [3:0]      op;
    logic [1:0]      signSel;
    logic            isMemOp, isBmapOp, isRegWrOp, isDmemWrOp, isCmpOp;

    // Effective opcode: any set bit above the low nibble turns the instruction into a NOP.
    always_comb begin
        op = 4'h0;
        if ((opReg >> 4) == '0) begin
            op = opReg[3:0];
        end
    end

    assign isMemOp    = op inside {4'b0110, 4'b0111, 4'b1110, 4'b1111};
    assign isBmapOp   = op inside {4'b1010, 4'b1011, 4'b1101};
    assign isRegWrOp  = op inside {4'b0010, 4'b0011, 4'b0110, 4'b1001};
    assign isDmemWrOp = op inside {4'b0111, 4'b1110};
    assign isCmpOp    = op inside {4'b1010, 4'b1011};

    // Immediate extension select derived from the latched opcode.
    always_comb begin
        case (op)
            4'b0110, 4'b0111: signSel = 2'b11;
            4'b1110, 4'b1111: signSel = 2'b10;
            4'b1001:          signSel = 2'b01;
            default:          signSel = 2'b00;
        endcase
    end

    // State register, opcode latch, beat counter and memory-wait counter; Stall freezes all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            opReg   <= '0;
            beatCnt <= '0;
            toutCnt <= '0;
        end else begin
            state <= nextState;
            if (state == S_FETCH && InstrValid && !Stall) begin
                opReg <= OpCode;
            end
            if (state == S_BMAP && !Stall) begin
                beatCnt <= (beatCnt == LAST_BEAT) ? '0 : beatCnt + 1'b1;
            end
            if (state == S_MEM && !Stall) begin
                toutCnt <= (DMemReady || toutCnt == LAST_WAIT) ? '0 : toutCnt + 1'b1;
            end
        end
    end

    // Next-state and per-state strobes; Stall masks writes, reset forces the idle FETCH pattern.
    always_comb begin
        nextState   = state;
        InstrReq    = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        BitmapWrite = 1'b0;
        BeatIdx     = beatCnt;
        DMemEn      = 1'b0;
        DMemWrite   = 1'b0;
        SignEx      = 2'b00;
        ALUAdd      = 1'b0;
        ALUSub      = 1'b0;
        CompAcc     = 1'b0;
        MemErr      = 1'b0;
        Busy        = 1'b1;
        Halted      = 1'b0;

        case (state)
            S_FETCH: begin
                InstrReq = 1'b1;
                Busy     = 1'b0;
                if (InstrValid) begin
                    nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                SignEx    = signSel;
                nextState = S_EXEC;
            end
            S_EXEC: begin
                SignEx  = signSel;
                ALUAdd  = (op == 4'b0011);
                ALUSub  = (op == 4'b0010);
                CompAcc = isCmpOp;
                if (isMemOp) begin
                    nextState = S_MEM;
                end else if (isBmapOp) begin
                    nextState = S_BMAP;
                end else if (op == 4'b0001) begin
                    nextState = S_HALT;
                end else begin
                    nextState = S_WB;
                end
            end
            S_MEM: begin
                SignEx    = signSel;
                DMemEn    = 1'b1;
                DMemWrite = isDmemWrOp;
                if (DMemReady) begin
                    nextState = (op == 4'b1111) ? S_BMAP : S_WB;
                end else if (toutCnt == LAST_WAIT) begin
                    MemErr    = 1'b1;
                    nextState = S_HALT;
                end
            end
            S_BMAP: begin
                SignEx      = signSel;
                BitmapWrite = 1'b1;
                CompAcc     = isCmpOp;
                if (beatCnt == LAST_BEAT) begin
                    nextState = S_WB;
                end
            end
            S_WB: begin
                SignEx    = signSel;
                RegWrite  = isRegWrOp;
                PCWrite   = 1'b1;
                nextState = S_FETCH;
            end
            S_HALT: begin
                Busy   = 1'b0;
                Halted = 1'b1;
            end
            default: begin
                nextState = S_FETCH;
            end
        endcase

        if (Stall) begin
            nextState   = state;
            PCWrite     = 1'b0;
            RegWrite    = 1'b0;
            BitmapWrite = 1'b0;
            DMemEn      = 1'b0;
            DMemWrite   = 1'b0;
            MemErr      = 1'b0;
        end

        if (rst) begin
            InstrReq    = 1'b1;
            PCWrite     = 1'b0;
            RegWrite    = 1'b0;
            BitmapWrite = 1'b0;
            BeatIdx     = '0;
            DMemEn      = 1'b0;
            DMemWrite   = 1'b0;
            SignEx      = 2'b00;
            ALUAdd      = 1'b0;
            ALUSub      = 1'b0;
            CompAcc     = 1'b0;
            MemErr      = 1'b0;
            Busy        = 1'b0;
            Halted      = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle input/expected-output vectors checked through a scoreboard queue.
// Latency: one vector per clock; expected outputs compared mid-cycle on the falling edge.
// Backpressure: Stall and DMemReady are driven from the vectors themselves.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       InstrValid = 1'b0;
    logic [3:0] OpCode = 4'h0;
    logic       DMemReady = 1'b0;
    logic       Stall = 1'b0;
    logic       InstrReq, PCWrite, RegWrite, BitmapWrite;
    logic [3:0] BeatIdx;
    logic       DMemEn, DMemWrite;
    logic [1:0] SignEx;
    logic       ALUAdd, ALUSub, CompAcc, MemErr, Busy, Halted;

    typedef struct packed {
        logic       instrReq, pcWrite, regWrite, bitmapWrite;
        logic [3:0] beatIdx;
        logic       dmemEn, dmemWrite;
        logic [1:0] signEx;
        logic       aluAdd, aluSub, compAcc, memErr, busy, halted;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst, iv;
        logic [3:0] op;
        logic       rdy, stall;
        outs_t      exp;
    } vec_t;

    vec_t  vecs[$];
    vec_t  sbQ[$];
    outs_t act;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    multicycle_controller #(.OP_W(4), .BM_BEATS(8), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .InstrValid(InstrValid), .OpCode(OpCode),
        .DMemReady(DMemReady), .Stall(Stall), .InstrReq(InstrReq), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .BitmapWrite(BitmapWrite), .BeatIdx(BeatIdx),
        .DMemEn(DMemEn), .DMemWrite(DMemWrite), .SignEx(SignEx), .ALUAdd(ALUAdd),
        .ALUSub(ALUSub), .CompAcc(CompAcc), .MemErr(MemErr), .Busy(Busy), .Halted(Halted)
    );

    always #5 clk = ~clk;

    assign act = {InstrReq, PCWrite, RegWrite, BitmapWrite, BeatIdx, DMemEn, DMemWrite,
                  SignEx, ALUAdd, ALUSub, CompAcc, MemErr, Busy, Halted};

    // Expected-output builder, fields in port order.
    function automatic outs_t e(input logic ir, pc, rw, bw, input int bi, input logic en, wr,
                                input logic [1:0] se, input logic add, sub, cmp, err, busy, halt);
        return {ir, pc, rw, bw, 4'(bi), en, wr, se, add, sub, cmp, err, busy, halt};
    endfunction

    function automatic outs_t idleF();
        return e(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic outs_t busyOnly(input logic [1:0] se);
        return e(0, 0, 0, 0, 0, 0, 0, se, 0, 0, 0, 0, 1, 0);
    endfunction

    function automatic outs_t haltO();
        return e(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic v(input string n, input logic r, iv, input logic [3:0] op,
                     input logic rdy, st, input outs_t x);
        vec_t t;
        t.name = n; t.rst = r; t.iv = iv; t.op = op; t.rdy = rdy; t.stall = st; t.exp = x;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs, queue its expectation, then compare mid-cycle.
    task automatic step(input vec_t t);
        vec_t got;
        @(posedge clk);
        #1;
        rst = t.rst; InstrValid = t.iv; OpCode = t.op; DMemReady = t.rdy; Stall = t.stall;
        sbQ.push_back(t);
        @(negedge clk);
        got = sbQ.pop_front();
        checks++;
        if (act !== got.exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", got.name, cyc, act, got.exp);
        end
        cyc++;
    endtask

    task automatic hs(input string n, input logic r, iv, input logic [3:0] op,
                      input logic rdy, st, input outs_t x);
        vec_t t;
        t.name = n; t.rst = r; t.iv = iv; t.op = op; t.rdy = rdy; t.stall = st; t.exp = x;
        step(t);
    endtask

    initial begin
        // Reset, then ADD: InstrReq c0, ALUAdd c2, RegWrite+PCWrite c3, FETCH c4.
        v("reset0",    1, 0, 4'h0, 0, 0, idleF());
        v("reset1",    1, 0, 4'h0, 0, 0, idleF());
        v("add_fetch", 0, 1, 4'h3, 0, 0, idleF());
        v("add_dec",   0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        v("add_exec",  0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 1, 0));
        v("add_wb",    0, 0, 4'h0, 0, 0, e(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0));
        v("add_next",  0, 0, 4'h0, 0, 0, idleF());
        // SUB.
        v("sub_fetch", 0, 1, 4'h2, 0, 0, idleF());
        v("sub_dec",   0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        v("sub_exec",  0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1, 0));
        v("sub_wb",    0, 0, 4'h0, 0, 0, e(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0));
        // Store 0111, ready on third MEM cycle.
        v("st_fetch",  0, 1, 4'h7, 0, 0, idleF());
        v("st_dec",    0, 0, 4'h0, 0, 0, busyOnly(2'b11));
        v("st_exec",   0, 0, 4'h0, 0, 0, busyOnly(2'b11));
        v("st_mem1",   0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 1, 1, 2'b11, 0, 0, 0, 0, 1, 0));
        v("st_mem2",   0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 1, 1, 2'b11, 0, 0, 0, 0, 1, 0));
        v("st_mem3",   0, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 0, 1, 1, 2'b11, 0, 0, 0, 0, 1, 0));
        v("st_wb",     0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 1, 0));
        v("st_next",   0, 0, 4'h0, 0, 0, idleF());
        // Compare-bitmap 1011: eight beats with CompAcc from EXEC through last beat.
        v("bm_fetch",  0, 1, 4'hB, 0, 0, idleF());
        v("bm_dec",    0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        v("bm_exec",   0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
        for (int b = 0; b < 8; b++)
            v("bm_beat", 0, 0, 4'h0, 0, 0, e(0, 0, 0, 1, b, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
        v("bm_wb",     0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0));
        // NOP opcode 1000: only PCWrite.
        v("nop_fetch", 0, 1, 4'h8, 0, 0, idleF());
        v("nop_dec",   0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        v("nop_exec",  0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        v("nop_wb",    0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0));
        // 1001: SignEx 01 and RegWrite.
        v("i9_fetch",  0, 1, 4'h9, 0, 0, idleF());
        v("i9_dec",    0, 0, 4'h0, 0, 0, busyOnly(2'b01));
        v("i9_exec",   0, 0, 4'h0, 0, 0, busyOnly(2'b01));
        v("i9_wb",     0, 0, 4'h0, 0, 0, e(0, 1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 0));
        // 1110: ready exactly on the 16th MEM cycle still succeeds.
        v("ld_fetch",  0, 1, 4'hE, 0, 0, idleF());
        v("ld_dec",    0, 0, 4'h0, 0, 0, busyOnly(2'b10));
        v("ld_exec",   0, 0, 4'h0, 0, 0, busyOnly(2'b10));
        for (int m = 0; m < 15; m++)
            v("ld_wait", 0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 1, 0));
        v("ld_edge",   0, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 1, 0));
        v("ld_wb",     0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0));
        // 1111 never ready: MemErr on 16th MEM cycle, then HALT until reset.
        v("to_fetch",  0, 1, 4'hF, 0, 0, idleF());
        v("to_dec",    0, 0, 4'h0, 0, 0, busyOnly(2'b10));
        v("to_exec",   0, 0, 4'h0, 0, 0, busyOnly(2'b10));
        for (int m = 0; m < 15; m++)
            v("to_wait", 0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0, 1, 0));
        v("to_err",    0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 1, 1, 0));
        for (int h = 0; h < 4; h++)
            v("to_halt", 0, 1, 4'h3, 1, 0, haltO());
        v("to_rst",    1, 0, 4'h0, 0, 0, idleF());
        v("to_after",  0, 0, 4'h0, 0, 0, idleF());

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // 1111 with ready: load then bitmap burst without CompAcc.
        hs("lb_fetch", 0, 1, 4'hF, 0, 0, idleF());
        hs("lb_dec",   0, 0, 4'h0, 0, 0, busyOnly(2'b10));
        hs("lb_exec",  0, 0, 4'h0, 0, 0, busyOnly(2'b10));
        hs("lb_mem",   0, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0, 1, 0));
        for (int b = 0; b < 8; b++)
            hs("lb_beat", 0, 0, 4'h0, 0, 0, e(0, 0, 0, 1, b, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0));
        hs("lb_wb",    0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0));

        // 1010 with a 3-cycle stall at beat 4: beat index held, writes masked, 8 beats in total.
        hs("st4_fetch", 0, 1, 4'hA, 0, 0, idleF());
        hs("st4_dec",   0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        hs("st4_exec",  0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
        for (int b = 0; b < 4; b++)
            hs("st4_beat", 0, 0, 4'h0, 0, 0, e(0, 0, 0, 1, b, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
        for (int s = 0; s < 3; s++)
            hs("st4_hold", 0, 0, 4'h0, 0, 1, e(0, 0, 0, 0, 4, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
        for (int b = 4; b < 8; b++)
            hs("st4_beat", 0, 0, 4'h0, 0, 0, e(0, 0, 0, 1, b, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
        hs("st4_wb",    0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0));

        // 0110 with stall over a ready pulse in MEM, then stall in WB.
        hs("sm_fetch", 0, 1, 4'h6, 0, 0, idleF());
        hs("sm_dec",   0, 0, 4'h0, 0, 0, busyOnly(2'b11));
        hs("sm_exec",  0, 0, 4'h0, 0, 0, busyOnly(2'b11));
        hs("sm_stall", 0, 0, 4'h0, 1, 1, busyOnly(2'b11));
        hs("sm_mem",   0, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 0, 1, 0, 2'b11, 0, 0, 0, 0, 1, 0));
        hs("sm_wbhld", 0, 0, 4'h0, 0, 1, busyOnly(2'b11));
        hs("sm_wb",    0, 0, 4'h0, 0, 0, e(0, 1, 1, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 1, 0));

        // 0110 aborted by reset during MEM: no strobes in reset cycle or after, no RegWrite.
        hs("ab_fetch", 0, 1, 4'h6, 0, 0, idleF());
        hs("ab_dec",   0, 0, 4'h0, 0, 0, busyOnly(2'b11));
        hs("ab_exec",  0, 0, 4'h0, 0, 0, busyOnly(2'b11));
        hs("ab_mem",   0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 2'b11, 0, 0, 0, 0, 1, 0));
        hs("ab_rst",   1, 0, 4'h0, 1, 0, idleF());
        hs("ab_post1", 0, 0, 4'h0, 1, 0, idleF());
        hs("ab_post2", 0, 0, 4'h0, 0, 0, idleF());

        // HALT opcode 0001.
        hs("h_fetch",  0, 1, 4'h1, 0, 0, idleF());
        hs("h_dec",    0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        hs("h_exec",   0, 0, 4'h0, 0, 0, busyOnly(2'b00));
        hs("h_halt1",  0, 1, 4'h3, 0, 0, haltO());
        hs("h_halt2",  0, 1, 4'h3, 0, 0, haltO());
        hs("h_rst",    1, 0, 4'h0, 0, 0, idleF());
        hs("h_after",  0, 0, 4'h0, 0, 0, idleF());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the CPU's single-cycle opcode decoder.
- Latches each instruction opcode and sequences it through FETCH/DECODE/EXEC plus optional MEM-wait, BITMAP-burst and WRITEBACK states.
- Drives datapath control strobes per state. Handles data-memory ready handshake with timeout, multi-beat bitmap writes, external stall and HALT.
- Sits between instruction fetch and the register file / bitmap store / data memory.

Parameters:
- OP_W, 4, opcode width; opcodes below use the low 4 bits, upper bits must be 0 or the opcode decodes as NOP.
- BM_BEATS, 8, rows written per bitmap-write instruction (>=1).
- MEM_TIMEOUT, 16, max cycles waiting for DMemReady before error (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- InstrValid  in  1  instruction word available from fetch
- OpCode  in  OP_W  opcode, sampled only in FETCH when InstrValid=1
- DMemReady  in  1  data memory completed access this cycle
- Stall  in  1  external hold; freezes state, counters and outputs
- InstrReq  out  1  request next instruction
- PCWrite  out  1  advance PC (one-cycle pulse)
- RegWrite  out  1  register file write
- BitmapWrite  out  1  bitmap store write (one per beat)
- BeatIdx  out  $clog2(BM_BEATS)+1  current bitmap row index
- DMemEn, DMemWrite  out  1 each  data memory enable / write
- SignEx  out  2  immediate extension select
- ALUAdd, ALUSub, CompAcc  out  1 each  ALU mode strobes
- MemErr  out  1  one-cycle pulse on memory timeout
- Busy  out  1  high in every state except FETCH and HALT
- Halted  out  1  high in HALT

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, BMAP, WB, HALT. Reset → FETCH; BeatIdx, timeout counter and latched opcode cleared; all outputs 0 except InstrReq=1.
- Reset mid-instruction aborts it; no strobe fires in the reset cycle or the cycle after.
- FETCH: InstrReq=1. On InstrValid, latch OpCode → DECODE; otherwise stay.
- DECODE: SignEx driven from the latched opcode:
  - 11 for 0110/0111
  - 10 for 1110/1111
  - 01 for 1001
  - 00 otherwise
  - Next state → EXEC. SignEx holds until WB/FETCH.
- EXEC, one cycle:
  - 0011: ALUAdd=1.
  - 0010: ALUSub=1.
  - 1010/1011: CompAcc=1.
  - Next state: 0110/0111/1110/1111 → MEM; 1010/1011/1101 → BMAP; 0001 → HALT; all others → WB.
- MEM:
  - DMemEn=1 throughout; DMemWrite=1 for 0111/1110.
  - On DMemReady: → BMAP if opcode 1111 (load-to-bitmap), else → WB.
  - Timeout counter increments each non-ready cycle. When it reaches MEM_TIMEOUT: MemErr pulse, → HALT.
  - DMemReady in the same cycle the count hits the limit counts as success.
- BMAP:
  - BitmapWrite=1 every cycle, BeatIdx = 0 … BM_BEATS-1.
  - After the beat with BeatIdx=BM_BEATS-1 → WB; BeatIdx returns to 0.
  - CompAcc stays high through BMAP for 1010/1011.
- WB:
  - RegWrite=1 for 0010, 0011, 0110, 1001; otherwise 0.
  - PCWrite=1 in every WB.
  - Next state → FETCH. Minimum instruction latency = 4 cycles (FETCH, DECODE, EXEC, WB).
- HALT: all strobes 0, Halted=1. Exit only by rst.
- Stall=1: hold state, BeatIdx and timeout counter. Every write/enable strobe (RegWrite, BitmapWrite, DMemEn, DMemWrite, PCWrite) is forced 0 that cycle; InstrReq held. Stall takes priority over DMemReady: the ready pulse is ignored and the timeout counter does not advance.
- Opcodes 0000, 0100, 0101, 1000, 1100 and any out-of-range opcode: NOP path, FETCH → DECODE → EXEC → WB with only PCWrite.

Test Plan:
- Reset, then opcode 0011 with InstrValid=1 → InstrReq cycle 0, ALUAdd=1 cycle 2, RegWrite=1 and PCWrite=1 cycle 3, FETCH cycle 4.
- Opcode 0111, DMemReady asserted on the 3rd MEM cycle → SignEx=11; DMemEn and DMemWrite high for exactly 3 cycles; no RegWrite; PCWrite in WB.
- Opcode 1011, BM_BEATS=8 → BitmapWrite high 8 consecutive cycles with BeatIdx 0..7; CompAcc high from EXEC through the last beat.
- Opcode 1111, DMemReady never asserted, MEM_TIMEOUT=16 → MemErr single pulse after 16 MEM cycles; Halted=1 and stays 1 until rst.
- Stall=1 for 3 cycles mid-BMAP at BeatIdx=4 → BitmapWrite=0 and BeatIdx=4 held throughout; resumes at 4; total beats = 8.
- rst asserted during MEM of opcode 0110 → next cycle state FETCH, all strobes 0, InstrReq=1, no RegWrite ever issued for the aborted load.
